// File: rtl/feature_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : feature_aggregator
// Description : GCN neighbour aggregation. Self-loop init from the product
//               buffer, then saturating agg[node1] += prod[node2] per edge.
// Revision    : 1.0 - initial release
// ============================================================================
module feature_aggregator #(
  parameter int NUM_NODES = 6,
  parameter int NUM_FEAT  = 3,
  parameter int DATA_W    = 8,
  parameter int ACC_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         prod_wr_en,
  input  logic [2:0]                   prod_wr_row,
  input  logic [NUM_FEAT*DATA_W-1:0]   prod_wr_data,
  input  logic                         start,
  input  logic                         enable_write_fm_wm_prod,
  input  logic [2:0]                   node1,
  input  logic [2:0]                   node2,
  input  logic                         coo_done,
  input  logic [2:0]                   read_row,
  output logic [NUM_FEAT*ACC_W-1:0]    read_data,
  output logic                         busy,
  output logic                         agg_done,
  output logic                         idx_err
);

  localparam logic [2:0]       c_max_idx = 3'(NUM_NODES - 1);
  localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_READY = 2'd3
  } state_t;

  state_t                      r_state;
  logic [2:0]                  r_cnt;
  logic [NUM_FEAT*DATA_W-1:0]  r_prod [NUM_NODES];
  logic [NUM_FEAT*ACC_W-1:0]   r_agg  [NUM_NODES];
  logic [NUM_FEAT*ACC_W-1:0]   r_read_data;
  logic                        r_busy;
  logic                        r_agg_done;
  logic                        r_idx_err;

  logic                        w_idx_ok;
  logic [2:0]                  w_n1;
  logic [2:0]                  w_n2;
  logic [NUM_FEAT*ACC_W-1:0]   w_upd_row;
  logic [NUM_FEAT*ACC_W-1:0]   w_init_row;

  assign w_idx_ok = (node1 <= c_max_idx) && (node2 <= c_max_idx);
  // Clamp the lookup indices so an illegal edge never reads outside the arrays.
  assign w_n1 = w_idx_ok ? node1 : 3'd0;
  assign w_n2 = w_idx_ok ? node2 : 3'd0;

  for (genvar f = 0; f < NUM_FEAT; f++) begin : g_feat
    logic [ACC_W-1:0]  w_acc;
    logic [DATA_W-1:0] w_prod;
    logic [DATA_W-1:0] w_self;
    logic [ACC_W:0]    w_sum;

    assign w_acc  = r_agg[w_n1][f*ACC_W +: ACC_W];
    assign w_prod = r_prod[w_n2][f*DATA_W +: DATA_W];
    assign w_self = r_prod[r_cnt][f*DATA_W +: DATA_W];

    // One guard bit: the two top bits differ exactly when the sum overflowed.
    assign w_sum = {w_acc[ACC_W-1], w_acc}
                 + {{(ACC_W+1-DATA_W){w_prod[DATA_W-1]}}, w_prod};

    assign w_upd_row[f*ACC_W +: ACC_W] =
        (w_sum[ACC_W] == w_sum[ACC_W-1]) ? w_sum[ACC_W-1:0]
      : (w_sum[ACC_W] ? c_acc_min : c_acc_max);

    assign w_init_row[f*ACC_W +: ACC_W] =
        {{(ACC_W-DATA_W){w_self[DATA_W-1]}}, w_self};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_read_data <= '0;
      r_busy      <= 1'b0;
      r_agg_done  <= 1'b0;
      r_idx_err   <= 1'b0;
      for (int i = 0; i < NUM_NODES; i++) begin
        r_prod[i] <= '0;
        r_agg[i]  <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (prod_wr_en && (prod_wr_row <= c_max_idx)) begin
            r_prod[prod_wr_row] <= prod_wr_data;
          end
          if (start) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end

        ST_INIT: begin
          r_agg[r_cnt] <= w_init_row;
          if (r_cnt == c_max_idx) begin
            r_cnt   <= '0;
            r_state <= ST_ACCUM;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end

        // The update reads the registered row each cycle, so back-to-back
        // strobes to one node always see the previous result.
        ST_ACCUM: begin
          if (enable_write_fm_wm_prod) begin
            if (w_idx_ok) begin
              r_agg[node1] <= w_upd_row;
            end else begin
              r_idx_err <= 1'b1;
            end
          end
          if (coo_done) begin
            r_state    <= ST_READY;
            r_busy     <= 1'b0;
            r_agg_done <= 1'b1;
          end
        end

        ST_READY: begin
          if (read_row <= c_max_idx) begin
            r_read_data <= r_agg[read_row];
          end else begin
            r_read_data <= '0;
            r_idx_err   <= 1'b1;
          end
          if (start) begin
            r_state    <= ST_IDLE;
            r_agg_done <= 1'b0;
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_agg_done <= 1'b0;
        end
      endcase
    end
  end

  assign read_data = r_read_data;
  assign busy      = r_busy;
  assign agg_done  = r_agg_done;
  assign idx_err   = r_idx_err;

endmodule
`default_nettype wire

// File: tb/tb_feature_aggregator.sv
`default_nettype none
// ============================================================================
// Module      : tb_feature_aggregator
// Description : Directed + randomized bench for feature_aggregator against an
//               integer-arithmetic reference of the aggregation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_feature_aggregator;

  localparam int N  = 6;
  localparam int F  = 3;
  localparam int DW = 8;
  localparam int AW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            prod_wr_en;
  logic [2:0]      prod_wr_row;
  logic [F*DW-1:0] prod_wr_data;
  logic            start;
  logic            enable_write_fm_wm_prod;
  logic [2:0]      node1;
  logic [2:0]      node2;
  logic            coo_done;
  logic [2:0]      read_row;
  logic [F*AW-1:0] read_data;
  logic            busy;
  logic            agg_done;
  logic            idx_err;

  feature_aggregator #(.NUM_NODES(N), .NUM_FEAT(F), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .prod_wr_en              (prod_wr_en),
    .prod_wr_row             (prod_wr_row),
    .prod_wr_data            (prod_wr_data),
    .start                   (start),
    .enable_write_fm_wm_prod (enable_write_fm_wm_prod),
    .node1                   (node1),
    .node2                   (node2),
    .coo_done                (coo_done),
    .read_row                (read_row),
    .read_data               (read_data),
    .busy                    (busy),
    .agg_done                (agg_done),
    .idx_err                 (idx_err)
  );

  always #5 clk = ~clk;

  int              total = 0;
  int              bad   = 0;
  int              prod_m [N][F];
  int              agg_m  [N][F];
  bit              err_m;
  logic [F*AW-1:0] rd_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [F*AW-1:0] agg_row(input int r);
    logic [F*AW-1:0] v;
    v = '0;
    if (r < N) for (int f = 0; f < F; f++) v[f*AW +: AW] = 16'(agg_m[r][f]);
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++)
      for (int f = 0; f < F; f++) begin
        prod_m[r][f] = 0;
        agg_m[r][f]  = 0;
      end
    err_m = 1'b0;
    rd_m  = '0;
  endtask

  task automatic write_prod(input int r, input int e0, input int e1, input int e2);
    prod_wr_en   = 1'b1;
    prod_wr_row  = 3'(r);
    prod_wr_data = {8'(e2), 8'(e1), 8'(e0)};
    tick();
    prod_wr_en   = 1'b0;
    prod_m[r][0] = e0;
    prod_m[r][1] = e1;
    prod_m[r][2] = e2;
  endtask

  // Start from IDLE; a valid strobe is held during INIT and must have no effect.
  task automatic run_init();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_in_init", 64'(busy), 64'd1);
    enable_write_fm_wm_prod = 1'b1;
    node1 = 3'd0;
    node2 = 3'd1;
    repeat (N) tick();
    enable_write_fm_wm_prod = 1'b0;
    for (int r = 0; r < N; r++)
      for (int f = 0; f < F; f++) agg_m[r][f] = prod_m[r][f];
    chk("busy_in_accum", 64'(busy), 64'd1);
    chk("done_in_accum", 64'(agg_done), 64'd0);
  endtask

  task automatic strobe(input int n1, input int n2, input bit cd);
    enable_write_fm_wm_prod = 1'b1;
    node1    = 3'(n1);
    node2    = 3'(n2);
    coo_done = cd;
    tick();
    enable_write_fm_wm_prod = 1'b0;
    coo_done = 1'b0;
    if (n1 >= N || n2 >= N) err_m = 1'b1;
    else for (int f = 0; f < F; f++) agg_m[n1][f] = sat(agg_m[n1][f] + prod_m[n2][f]);
  endtask

  task automatic end_accum();
    coo_done = 1'b1;
    tick();
    coo_done = 1'b0;
    chk("done_in_ready", 64'(agg_done), 64'd1);
    chk("busy_in_ready", 64'(busy), 64'd0);
  endtask

  task automatic read_chk(input int r);
    read_row = 3'(r);
    tick();
    rd_m = agg_row(r);
    if (r >= N) err_m = 1'b1;
    chk($sformatf("read_row%0d", r), 64'(read_data), 64'(rd_m));
    chk("idx_err", 64'(idx_err), 64'(err_m));
  endtask

  // READY -> IDLE; the leaving edge still samples read_row.
  task automatic leave_ready();
    start = 1'b1;
    tick();
    start = 1'b0;
    rd_m = agg_row(int'(read_row));
    if (int'(read_row) >= N) err_m = 1'b1;
    chk("done_in_idle", 64'(agg_done), 64'd0);
    chk("busy_in_idle", 64'(busy), 64'd0);
    tick();
    chk("read_hold_idle", 64'(read_data), 64'(rd_m));
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    int         ns;

    reset = 1'b1; prod_wr_en = 1'b0; prod_wr_row = '0; prod_wr_data = '0;
    start = 1'b0; enable_write_fm_wm_prod = 1'b0; node1 = '0; node2 = '0;
    coo_done = 1'b0; read_row = '0;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(agg_done), 64'd0);
    chk("rst_idx_err", 64'(idx_err), 64'd0);
    chk("rst_read_data", 64'(read_data), 64'd0);

    // Self-loop only
    for (int r = 0; r < N; r++) write_prod(r, r + 1, r + 1, r + 1);
    run_init();
    end_accum();
    read_chk(3);
    chk("selfloop_row3_const", 64'(read_data), 64'h0004_0004_0004);
    leave_ready();

    // Cross edges and back-to-back strobes on one node
    run_init();
    strobe(0, 1, 1'b0);
    strobe(1, 0, 1'b0);
    strobe(2, 5, 1'b0);
    strobe(2, 5, 1'b0);
    strobe(2, 5, 1'b0);
    strobe(7, 0, 1'b0);
    chk("idx_err_node1_7", 64'(idx_err), 64'd1);
    strobe(3, 6, 1'b1);
    chk("done_with_last_strobe", 64'(agg_done), 64'd1);
    for (int r = 0; r < N; r++) read_chk(r);
    read_chk(0);
    chk("edge_row0_const", 64'(read_data), 64'h0003_0003_0003);
    read_chk(1);
    chk("edge_row1_const", 64'(read_data), 64'h0003_0003_0003);
    read_chk(2);
    chk("edge_row2_const", 64'(read_data), 64'h0015_0015_0015);
    read_chk(7);
    read_chk(4);
    leave_ready();

    // Randomized rounds; a write attempted in READY must be ignored
    for (int round = 0; round < 5; round++) begin
      for (int r = 0; r < N; r++) begin
        if ($urandom_range(0, 2) != 0) begin
          b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
          write_prod(r, int'($signed(b0)), int'($signed(b1)), int'($signed(b2)));
        end
      end
      run_init();
      ns = $urandom_range(8, 40);
      for (int k = 0; k < ns; k++) begin
        if ($urandom_range(0, 19) == 0) strobe(7 - $urandom_range(0, 1), $urandom_range(0, 5), k == ns - 1);
        else strobe($urandom_range(0, 5), $urandom_range(0, 5), k == ns - 1);
      end
      prod_wr_en   = 1'b1;
      prod_wr_row  = 3'd2;
      prod_wr_data = 24'($urandom);
      for (int r = 0; r < N; r++) read_chk(r);
      prod_wr_en = 1'b0;
      leave_ready();
    end

    // Saturation in both directions plus a non-saturating lane
    write_prod(0, 127, -128, 5);
    run_init();
    for (int k = 0; k < 300; k++) strobe(0, 0, 1'b0);
    end_accum();
    read_chk(0);
    chk("sat_row0_const", 64'(read_data), 64'h05E1_8000_7FFF);
    leave_ready();

    // Reset in the middle of ACCUM
    run_init();
    strobe(1, 2, 1'b0);
    strobe(3, 4, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(agg_done), 64'd0);
    chk("midrst_idx_err", 64'(idx_err), 64'd0);
    chk("midrst_read_data", 64'(read_data), 64'd0);
    run_init();
    end_accum();
    for (int r = 0; r < N; r++) read_chk(r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/feature_aggregator.md
FEATURE_AGGREGATOR -- requirements
Module: feature_aggregator

Interface
REQ-001 Parameter NUM_NODES, default 6: number of graph nodes (rows); node indices 0..NUM_NODES-1, 3-bit.
REQ-002 Parameter NUM_FEAT, default 3: features per row.
REQ-003 Parameter DATA_W, default 8: signed width of one FM*WM product element.
REQ-004 Parameter ACC_W, default 16: signed width of one aggregated element.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 prod_wr_en  input  1  write one product row into the product buffer.
REQ-008 prod_wr_row  input  3  product buffer row to write.
REQ-009 prod_wr_data  input  NUM_FEAT*DATA_W  packed signed product row, element 0 in LSBs.
REQ-010 start  input  1  begin self-loop init, then edge accumulation.
REQ-011 enable_write_fm_wm_prod  input  1  edge strobe from the COO FSM: agg[node1] += prod[node2].
REQ-012 node1  input  3  destination row of the edge strobe.
REQ-013 node2  input  3  source product row of the edge strobe.
REQ-014 coo_done  input  1  COO FSM done level; ends accumulation.
REQ-015 read_row  input  3  aggregate row to read in READY.
REQ-016 read_data  output  NUM_FEAT*ACC_W  registered aggregate row, element 0 in LSBs.
REQ-017 busy  output  1  high in INIT and ACCUM.
REQ-018 agg_done  output  1  high in READY.
REQ-019 idx_err  output  1  sticky: an out-of-range index was seen.

Function
REQ-020 States: IDLE, INIT, ACCUM, READY; encoding is free.
REQ-021 IDLE: prod_wr_en writes prod[prod_wr_row] <= prod_wr_data in the same edge; writes are ignored in every other state.
REQ-022 IDLE and start=1 -> INIT with internal row counter = 0.
REQ-023 INIT: each cycle, agg[cnt] <= sign-extended prod[cnt] (self-loop) and cnt increments; after row NUM_NODES-1 -> ACCUM; INIT lasts exactly NUM_NODES cycles.
REQ-024 enable_write_fm_wm_prod during INIT is ignored; the upstream FSM starts edges no earlier than ACCUM.
REQ-025 ACCUM: each cycle with enable_write_fm_wm_prod=1 performs agg[node1][f] <= sat(agg[node1][f] + sext(prod[node2][f])) for all f in one cycle; one update per cycle.
REQ-026 Saturation: a sum above 2^(ACC_W-1)-1 clamps to that value; a sum below -2^(ACC_W-1) clamps to that value.
REQ-027 Back-to-back strobes to the same node1 SHALL accumulate both updates (read-modify-write uses the updated value; no lost update).
REQ-028 node1 or node2 >= NUM_NODES (incl. 3'b111 from 1-based index 0): no write, idx_err <= 1.
REQ-029 ACCUM and coo_done=1 -> READY; a strobe in that same cycle is still applied.
REQ-030 READY: read_data <= agg[read_row] each cycle (1-cycle latency); read_row >= NUM_NODES returns 0 and sets idx_err.
REQ-031 READY and start=1 -> IDLE; product buffer kept, aggregate buffer kept until the next INIT overwrites it.
REQ-032 read_data holds its last value outside READY.

Reset
REQ-033 reset=1 at any edge, including mid-INIT or mid-ACCUM: state <= IDLE, counter <= 0, read_data <= 0, idx_err <= 0, all prod and agg entries <= 0.
REQ-034 After reset: busy=0, agg_done=0, idx_err=0, read_data=0.

Verification
REQ-035 Load prod rows r=0..5 with elements {r+1, r+1, r+1}, start, no edges, coo_done -> after 6 INIT cycles READY; read row 3 -> {4,4,4} one cycle later.
REQ-036 Same load, strobes (node1=0,node2=1) then (node1=1,node2=0) -> agg[0]={3,3,3}, agg[1]={3,3,3}.
REQ-037 Three consecutive strobes (node1=2,node2=5) -> agg[2]={3+18,...}={21,21,21}.
REQ-038 prod[0]={127,127,127}, ACC_W=8, 2 strobes (node1=0,node2=0) -> agg[0] saturates to {127,127,127}; negative case with -128 clamps to -128.
REQ-039 Strobe with node1=7 -> no agg change, idx_err=1 until reset.
REQ-040 Reset asserted in ACCUM after 2 strobes -> IDLE next edge, read_data=0, all buffers 0, busy=0.
